// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer bus: request, operands, HI/LO moves and results.
// The master drives requests and sees status; the slave is the sequencer.
interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       Md_op;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Mthi;
  logic             Mtlo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;

  modport master (
    output start, Md_op, Read_data_1, Read_data_2, Mthi, Mtlo,
    input  Busy, Done, Hi_out, Lo_out
  );

  modport slave (
    input  start, Md_op, Read_data_1, Read_data_2, Mthi, Mtlo,
    output Busy, Done, Hi_out, Lo_out
  );
endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide controller owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied in a final fix-up cycle.
module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input logic           clock,
  input logic           reset,
  md_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(WIDTH - 1);

  // Two's-complement negation, wrapping at WIDTH bits.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + ONE_W;
  endfunction

  // Two's-complement negation of a full double-width product.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    neg_2w = ~v + ONE_2W;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               is_div_s;
  logic               is_signed_s;
  logic               div_by_zero_s;
  logic [WIDTH-1:0]   mag_a_s;
  logic [WIDTH-1:0]   mag_b_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_part_s;
  logic [WIDTH:0]     div_diff_s;
  logic [2*WIDTH-1:0] run_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi_s;
  logic [WIDTH-1:0]   fix_lo_s;

  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;
  assign bus.Hi_out = hi_r;
  assign bus.Lo_out = lo_r;

  // Operation decode and operand magnitudes (op bit 0 clear means signed).
  always_comb begin
    is_div_s      = op_r[1];
    is_signed_s   = ~op_r[0];
    div_by_zero_s = op_r[1] && (b_r == ZERO_W);
    if (is_signed_s && a_r[WIDTH-1]) begin
      mag_a_s = neg_w(a_r);
    end else begin
      mag_a_s = a_r;
    end
    if (is_signed_s && b_r[WIDTH-1]) begin
      mag_b_s = neg_w(b_r);
    end else begin
      mag_b_s = b_r;
    end
  end

  // One iteration step: shift-add for multiply, restoring subtract for divide.
  // Multiply keeps {partial product, multiplier} in acc; divide keeps
  // {remainder, dividend/quotient} and shifts quotient bits in from the right.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    div_part_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    div_diff_s = div_part_s - {1'b0, b_r};
    run_next_s = acc_r;
    if (is_div_s) begin
      if (!div_diff_s[WIDTH]) begin
        run_next_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        run_next_s = {div_part_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      run_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end
  end

  // Final HI/LO values with sign correction of the magnitude result.
  always_comb begin
    prod_s   = neg_res_r ? neg_2w(acc_r) : acc_r;
    fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (is_div_s) begin
      fix_lo_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      fix_hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH])
                           : acc_r[2*WIDTH-1:WIDTH];
    end else begin
      fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Next-state logic for the IDLE/PREP/RUN/FIX sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_s = ST_PREP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PREP: begin
        if (div_by_zero_s) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_FIX;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FIX:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered status: Busy follows the upcoming state, Done marks FIX.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_FIX);
    end
  end

  // Operand capture, magnitude/sign preparation and iteration datapath.
  // Divide by zero preloads the architectural result (remainder = original
  // dividend, quotient = all ones) and clears the sign flags so FIX passes it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_r      <= 2'b00;
      a_r       <= ZERO_W;
      b_r       <= ZERO_W;
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            op_r <= bus.Md_op;
            a_r  <= bus.Read_data_1;
            b_r  <= bus.Read_data_2;
          end
        end
        ST_PREP: begin
          cnt_r <= CNT_TOP;
          if (div_by_zero_s) begin
            acc_r     <= {a_r, ONES_W};
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
          end else begin
            a_r       <= mag_a_s;
            b_r       <= mag_b_s;
            neg_res_r <= is_signed_s & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_rem_r <= is_signed_s & a_r[WIDTH-1];
            acc_r     <= is_div_s ? {ZERO_W, mag_a_s} : {ZERO_W, mag_b_s};
          end
        end
        ST_RUN: begin
          acc_r <= run_next_s;
          if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_FIX: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // HI/LO: result write in FIX, otherwise moves in IDLE unless start wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_r <= ZERO_W;
      lo_r <= ZERO_W;
    end else if (state_r == ST_FIX) begin
      hi_r <= fix_hi_s;
      lo_r <= fix_lo_s;
    end else if ((state_r == ST_IDLE) && !bus.start) begin
      if (bus.Mthi) begin
        hi_r <= bus.Read_data_1;
      end
      if (bus.Mtlo) begin
        lo_r <= bus.Read_data_1;
      end
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: a cycle-level reference model computes
// results with plain 64-bit arithmetic and is compared every cycle, while
// each directed vector also checks hand-computed latency and HI/LO values.
module tb_md_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  md_sequencer_if #(.WIDTH(32)) bus ();

  md_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model state: cycles remaining in flight, pending and current HI/LO.
  int          m_left = 0;
  logic [63:0] m_pend = 64'h0;
  logic [31:0] m_hi   = 32'h0;
  logic [31:0] m_lo   = 32'h0;

  // Architectural result {HI, LO} from the instruction semantics.
  function automatic logic [63:0] model_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'h0;
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 32'h0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      2'b11: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else            p = {a % b, a / b};
      end
      default: p = 64'h0;
    endcase
    return p;
  endfunction

  function automatic int model_lat(input logic [1:0] op, input logic [31:0] b);
    return (op[1] && (b == 32'h0)) ? 2 : 34;
  endfunction

  // Cycle-level model of request acceptance, latency and HI/LO updates.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_hi   <= 32'h0;
      m_lo   <= 32'h0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_pend[63:32];
        m_lo <= m_pend[31:0];
      end
    end else if (bus.start) begin
      m_left <= model_lat(bus.Md_op, bus.Read_data_2);
      m_pend <= model_res(bus.Md_op, bus.Read_data_1, bus.Read_data_2);
    end else begin
      if (bus.Mthi) m_hi <= bus.Read_data_1;
      if (bus.Mtlo) m_lo <= bus.Read_data_1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(bus.Busy), 64'(m_left != 0));
      chk("cyc_done", 64'(bus.Done), 64'(m_left == 1));
      chk("cyc_hi",   64'(bus.Hi_out), 64'(m_hi));
      chk("cyc_lo",   64'(bus.Lo_out), 64'(m_lo));
    end
  end

  // Issue one operation, measure start-to-Done latency, then check HI/LO.
  // mid > 0 injects a competing start plus Mthi at that in-flight cycle.
  task automatic run_op(input string name, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic mtlo, input int mid, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat;
    bus.start       = 1'b1;
    bus.Md_op       = op;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    bus.Mtlo        = mtlo;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.Mtlo  = 1'b0;
    chk({name, "_busy1"}, 64'(bus.Busy), 64'h1);
    lat = 1;
    while (!bus.Done && lat < 100) begin
      if (lat == mid) begin
        bus.start       = 1'b1;
        bus.Md_op       = 2'b11;
        bus.Read_data_1 = 32'h0BAD_F00D;
        bus.Read_data_2 = 32'h0000_0003;
        bus.Mthi        = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.Mthi  = 1'b0;
      end
      @(posedge clock); #1;
      lat++;
    end
    bus.start = 1'b0;
    bus.Mthi  = 1'b0;
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    @(posedge clock); #1;
    chk({name, "_busy_end"}, 64'(bus.Busy), 64'h0);
    chk({name, "_hi"}, 64'(bus.Hi_out), 64'(exp_hi));
    chk({name, "_lo"}, 64'(bus.Lo_out), 64'(exp_lo));
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.Md_op       = 2'b00;
    bus.Read_data_1 = 32'h0;
    bus.Read_data_2 = 32'h0;
    bus.Mthi        = 1'b0;
    bus.Mtlo        = 1'b0;
    reset           = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    reset  = 1'b1;
    chk("rst_busy", 64'(bus.Busy), 64'h0);
    chk("rst_done", 64'(bus.Done), 64'h0);
    chk("rst_hi",   64'(bus.Hi_out), 64'h0);
    chk("rst_lo",   64'(bus.Lo_out), 64'h0);
    @(posedge clock); #1;

    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 0, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_mid", 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 5, 34,
           32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 0, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",      2'b11, 32'd100, 32'd7, 1'b0, 0, 34, 32'd2, 32'd14);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'h0, 1'b0, 0, 2,
           32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'h0, 1'b0, 0, 2,
           32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 34,
           32'h0000_0000, 32'h8000_0000);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 34,
           32'h4000_0000, 32'h0000_0000);

    // Move to HI while idle.
    bus.Mthi        = 1'b1;
    bus.Read_data_1 = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    bus.Mthi = 1'b0;
    chk("mthi_hi", 64'(bus.Hi_out), 64'hA5A5_A5A5);
    chk("mthi_lo", 64'(bus.Lo_out), 64'h0);

    // Mtlo together with start: operation wins, LO write dropped.
    run_op("mtlo_start", 2'b01, 32'd3, 32'd4, 1'b1, 0, 34, 32'd0, 32'd12);

    // Asynchronous reset in the middle of a multiply.
    bus.start       = 1'b1;
    bus.Md_op       = 2'b00;
    bus.Read_data_1 = 32'd9;
    bus.Read_data_2 = 32'd11;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("pre_rst_busy", 64'(bus.Busy), 64'h1);
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.Busy), 64'h0);
    chk("arst_hi",   64'(bus.Hi_out), 64'h0);
    chk("arst_lo",   64'(bus.Lo_out), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    run_op("post_rst", 2'b00, 32'd7, 32'hFFFF_FFFA, 1'b0, 0, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFD6);

    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
